// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Issues credit-limited requests to instruction memory.
// Queues the returned words in order, each paired with its request PC.
// Feeds the IF/ID register consumed by decode and the hazard detector.
// A redirect flushes all queued state and marks in-flight responses for discard.
//
// Handshake: a request transfers on any cycle with imem_req && imem_ready.
// While imem_req is high and not accepted, imem_addr and imem_req stay
// stable, because credit can only grow without an accept. Every accepted
// request yields exactly one imem_rvalid pulse, in order, at least one cycle
// later. The IF/ID side has no ready signal; stall holds it.
module fetch_unit #(
    parameter int          QDEPTH   = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [1:0]  pc_sel,
    input  logic [15:0] branch_target,
    input  logic [15:0] jump_target,
    input  logic [15:0] ret_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] IF_ID_Inst,
    output logic [15:0] IF_ID_PC,
    output logic        IF_ID_valid
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [15:0]   fetch_pc;
    logic [CW-1:0] outstanding;   // all in-flight requests, stale ones included
    logic [CW-1:0] drop_cnt;      // in-flight responses still to be discarded
    logic          rsp_ignore;    // responses before the first post-reset accept are stale

    logic [15:0]   pf_pc [QDEPTH];
    logic [PW-1:0] pf_wr, pf_rd;

    logic [15:0]   q_inst [QDEPTH];
    logic [15:0]   q_pc   [QDEPTH];
    logic [PW-1:0] q_head, q_tail;
    logic [CW-1:0] occ;

    logic          redirect;
    logic [15:0]   redirect_pc;
    logic          credit_ok;
    logic          accept;
    logic          rsp;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(QDEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Decode the redirect and the per-cycle request/response/pop events
    always_comb begin
        redirect    = branch_taken && (pc_sel != 2'b00);
        redirect_pc = fetch_pc;
        case (pc_sel)
            2'b01:   redirect_pc = branch_target;
            2'b10:   redirect_pc = jump_target;
            2'b11:   redirect_pc = ret_target;
            default: redirect_pc = fetch_pc;
        endcase
        // Credit uses registered counts only, so a same-cycle pop frees nothing yet
        credit_ok = ({1'b0, occ} + {1'b0, outstanding}) < (CW + 1)'(QDEPTH);
        imem_req  = !rst && !redirect && credit_ok;
        imem_addr = fetch_pc;
        accept    = imem_req && imem_ready;
        rsp       = imem_rvalid && !rsp_ignore && (outstanding != '0);
        rsp_drop  = rsp && (redirect || (drop_cnt != '0));
        rsp_keep  = rsp && !rsp_drop;
        pop       = !redirect && !stall && (occ != '0);
    end

    // Fetch PC, in-flight counters and the post-reset response filter
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            rsp_ignore  <= 1'b1;
        end else begin
            if (redirect)    fetch_pc <= redirect_pc;
            else if (accept) fetch_pc <= fetch_pc + 16'd1;
            if (accept) rsp_ignore <= 1'b0;
            outstanding <= outstanding + CW'(accept) - CW'(rsp);
            // Everything still in flight after this cycle's response is wrong-path
            if (redirect)      drop_cnt <= outstanding - CW'(rsp);
            else if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
        end
    end

    // Request-PC FIFO pointers: push on accept, pop on each kept response
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            pf_wr <= '0;
            pf_rd <= '0;
        end else begin
            if (accept)   pf_wr <= ptr_inc(pf_wr);
            if (rsp_keep) pf_rd <= ptr_inc(pf_rd);
        end
    end

    // Request-PC FIFO storage
    always_ff @(posedge clk) begin
        if (accept) pf_pc[pf_wr] <= fetch_pc;
    end

    // Instruction queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            q_head <= '0;
            q_tail <= '0;
            occ    <= '0;
        end else begin
            if (rsp_keep) q_tail <= ptr_inc(q_tail);
            if (pop)      q_head <= ptr_inc(q_head);
            occ <= occ + CW'(rsp_keep) - CW'(pop);
        end
    end

    // Instruction queue storage: returned word paired with its request PC
    always_ff @(posedge clk) begin
        if (rsp_keep) begin
            q_inst[q_tail] <= imem_rdata;
            q_pc[q_tail]   <= pf_pc[pf_rd];
        end
    end

    // IF/ID register: reset, then redirect flush, then stall hold, then pop or NOP
    always_ff @(posedge clk) begin
        if (rst) begin
            IF_ID_Inst  <= '0;
            IF_ID_PC    <= '0;
            IF_ID_valid <= 1'b0;
        end else if (redirect) begin
            IF_ID_Inst  <= '0;
            IF_ID_valid <= 1'b0;
        end else if (!stall) begin
            if (occ != '0) begin
                IF_ID_Inst  <= q_inst[q_head];
                IF_ID_PC    <= q_pc[q_head];
                IF_ID_valid <= 1'b1;
            end else begin
                IF_ID_Inst  <= '0;
                IF_ID_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a variable-latency,
// in-order instruction memory whose word at address a is a + 16'h1000.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [1:0]  pc_sel;
    logic [15:0] branch_target;
    logic [15:0] jump_target;
    logic [15:0] ret_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic [15:0] IF_ID_Inst;
    logic [15:0] IF_ID_PC;
    logic        IF_ID_valid;

    int          tests_run    = 0;
    int          tests_failed = 0;

    logic [31:0] exp_q[$];       // {pc, inst} in expected IF/ID order
    logic [47:0] mem_q[$];       // {due cycle, addr} of accepted requests
    logic [47:0] mem_head;
    int          cyc = 0;
    int          lat = 1;
    logic        mon_en    = 1'b0;
    logic        hold_edge = 1'b0;
    logic [15:0] prev_inst = '0;
    logic [15:0] prev_pc   = '0;
    logic        prev_valid = 1'b0;
    logic [31:0] mon_exp;

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    fetch_unit #(.QDEPTH(2), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .pc_sel(pc_sel), .branch_target(branch_target), .jump_target(jump_target),
        .ret_target(ret_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_ID_Inst(IF_ID_Inst), .IF_ID_PC(IF_ID_PC), .IF_ID_valid(IF_ID_valid)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a + 16'h1000;
    endfunction

    // Memory model: accept at an edge, answer lat cycles later, in order
    always @(posedge clk) begin
        cyc = cyc + 1;
        hold_edge <= stall && !(branch_taken && pc_sel != 2'b00) && !rst;
        if (rst) begin
            mem_q.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            if (imem_req && imem_ready) mem_q.push_back({32'(cyc + lat - 1), imem_addr});
            imem_rvalid <= 1'b0;
            if (mem_q.size() > 0) begin
                mem_head = mem_q[0];
                if (int'(mem_head[47:16]) <= cyc) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_word(mem_head[15:0]);
                    void'(mem_q.pop_front());
                end
            end
        end
    end

    // Scoreboard monitor: new IF/ID words pop the queue, stalled edges must hold
    always @(negedge clk) begin
        if (mon_en && hold_edge) begin
            tests_run++;
            if ({IF_ID_valid, IF_ID_PC, IF_ID_Inst} !== {prev_valid, prev_pc, prev_inst}) begin
                tests_failed++;
                $display("FAIL stall_hold: got v=%0b pc=%h inst=%h, required v=%0b pc=%h inst=%h",
                         IF_ID_valid, IF_ID_PC, IF_ID_Inst, prev_valid, prev_pc, prev_inst);
            end
        end else if (mon_en && IF_ID_valid && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            tests_run++;
            if ({IF_ID_PC, IF_ID_Inst} !== mon_exp) begin
                tests_failed++;
                $display("FAIL ifid_stream: got pc=%h inst=%h, required pc=%h inst=%h",
                         IF_ID_PC, IF_ID_Inst, mon_exp[31:16], mon_exp[15:0]);
            end
        end
        prev_valid = IF_ID_valid;
        prev_pc    = IF_ID_PC;
        prev_inst  = IF_ID_Inst;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int l);
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; pc_sel = 2'b00;
        imem_ready = 1'b1; lat = l; mon_en = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_seq(input logic [15:0] start, input int n);
        logic [15:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({a, mem_word(a)});
            a = a + 16'd1;
        end
    endtask

    task automatic wait_drain(input int limit, output bit ok);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (exp_q.size() == 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        bit ok;
        do_reset(2);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_req: got %0b, required 0", imem_req);
        end
        @(negedge clk);
        tests_run++;
        if ({IF_ID_valid, IF_ID_PC, IF_ID_Inst} !== 33'd0) begin
            tests_failed++;
            $display("FAIL reset_ifid: got v=%0b pc=%h inst=%h, required all zero",
                     IF_ID_valid, IF_ID_PC, IF_ID_Inst);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_first_req: got req=%0b addr=%h, required req=1 addr=0000",
                     imem_req, imem_addr);
        end
        push_seq(16'h0000, 4);
        mon_en = 1'b1;
        wait_drain(60, ok);
        mon_en = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL reset_drain: %0d words not delivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_stream;
        bit ok;
        do_reset(1);
        push_seq(16'h0000, 16);
        mon_en = 1'b1;
        wait_drain(200, ok);
        mon_en = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL stream_drain: %0d words not delivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_stall;
        bit ok;
        do_reset(1);
        push_seq(16'h0000, 12);
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        stall = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_credit: got req=%0b, required 0", imem_req);
        end
        @(negedge clk);
        stall = 1'b0;
        wait_drain(200, ok);
        mon_en = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL stall_drain: %0d words not delivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_redirect_lat3;
        bit ok;
        int n;
        do_reset(3);
        push_seq(16'h0040, 6);
        mon_en = 1'b1;
        n = 0;
        while (mem_q.size() != 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (mem_q.size() != 2) begin
            tests_failed++;
            $display("FAIL two_inflight: got %0d in flight, required 2", mem_q.size());
        end
        branch_taken = 1'b1; pc_sel = 2'b01; branch_target = 16'h0040;
        #1;
        tests_run++;
        if (imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL redirect_no_req: got req=%0b, required 0", imem_req);
        end
        @(negedge clk);
        branch_taken = 1'b0; pc_sel = 2'b00;
        tests_run++;
        if (IF_ID_valid !== 1'b0 || imem_addr !== 16'h0040) begin
            tests_failed++;
            $display("FAIL redirect_flush: got valid=%0b addr=%h, required valid=0 addr=0040",
                     IF_ID_valid, imem_addr);
        end
        n = 1;
        while (!IF_ID_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (!IF_ID_valid || n < 3) begin
            tests_failed++;
            $display("FAIL redirect_penalty: got valid=%0b after %0d cycles, required valid after >=3",
                     IF_ID_valid, n);
        end
        wait_drain(200, ok);
        mon_en = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL redirect_drain: %0d words not delivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_redirect_stall;
        bit ok;
        int n;
        do_reset(1);
        n = 0;
        while (!IF_ID_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (!IF_ID_valid) begin
            tests_failed++;
            $display("FAIL stream_start: got valid=0, required 1");
        end
        stall = 1'b1; branch_taken = 1'b1; pc_sel = 2'b11; ret_target = 16'h0123;
        push_seq(16'h0123, 6);
        @(negedge clk);
        branch_taken = 1'b0; pc_sel = 2'b00;
        tests_run++;
        if (IF_ID_valid !== 1'b0 || imem_addr !== 16'h0123) begin
            tests_failed++;
            $display("FAIL redirect_over_stall: got valid=%0b addr=%h, required valid=0 addr=0123",
                     IF_ID_valid, imem_addr);
        end
        mon_en = 1'b1;
        @(negedge clk);
        stall = 1'b0;
        wait_drain(200, ok);
        mon_en = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL ret_drain: %0d words not delivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_no_redirect;
        bit ok;
        do_reset(1);
        push_seq(16'h0000, 20);
        mon_en = 1'b1;
        repeat (6) @(negedge clk);
        branch_taken = 1'b1; pc_sel = 2'b00;
        branch_target = 16'h0200; jump_target = 16'h0300; ret_target = 16'h0400;
        repeat (2) @(negedge clk);
        branch_taken = 1'b0;
        wait_drain(200, ok);
        mon_en = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL pcsel00_drain: %0d words not delivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_wrap_ready;
        bit          ok;
        logic [3:0]  pat;
        logic        prev_pend;
        logic [15:0] prev_addr;
        pat = 4'b1001;   // ready sequence 1,0,0,1
        prev_pend = 1'b0;
        prev_addr = '0;
        do_reset(1);
        branch_taken = 1'b1; pc_sel = 2'b10; jump_target = 16'hFFFE;
        push_seq(16'hFFFE, 6);
        mon_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            branch_taken = 1'b0; pc_sel = 2'b00;
            imem_ready = pat[i % 4];
            #1;
            if (prev_pend) begin
                tests_run++;
                if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    tests_failed++;
                    $display("FAIL addr_hold: got req=%0b addr=%h, required req=1 addr=%h",
                             imem_req, imem_addr, prev_addr);
                end
            end
            prev_pend = imem_req && !imem_ready;
            prev_addr = imem_addr;
        end
        imem_ready = 1'b1;
        wait_drain(100, ok);
        mon_en = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL wrap_drain: %0d words not delivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_random_stall;
        bit ok;
        do_reset($urandom_range(1, 3));
        push_seq(16'h0000, 30);
        mon_en = 1'b1;
        for (int i = 0; i < 150 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            stall      = ($urandom_range(0, 3) == 0);
            imem_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        stall = 1'b0; imem_ready = 1'b1;
        wait_drain(300, ok);
        mon_en = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL random_drain: %0d words not delivered, required 0", exp_q.size());
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; pc_sel = 2'b00;
        branch_target = '0; jump_target = '0; ret_target = '0; imem_ready = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_lat3();
        test_redirect_stall();
        test_no_redirect();
        test_wrap_ready();
        test_random_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
